// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Bundle of the writeback arbiter's bus signals. This covers
//                pipeline writeback (A), multi-cycle result (B), the
//                register-file write port, stall and hazard signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
    // Port A: pipeline writeback, never backpressured
    logic        a_we;
    logic [3:0]  a_dest;
    logic [31:0] a_data;
    // Port B: multi-cycle unit result
    logic        b_valid;
    logic [3:0]  b_dest;
    logic [31:0] b_data;
    logic        b_ready;
    // Register-file write port
    logic        wr_en;
    logic [3:0]  wr_dest;
    logic [31:0] wr_data;
    // Status
    logic        stall_req;
    logic [3:0]  fifo_count;
    // Hazard lookup against buffered results
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        hazard1;
    logic        hazard2;

    modport slave (
        input  a_we, a_dest, a_data,
        input  b_valid, b_dest, b_data,
        output b_ready,
        output wr_en, wr_dest, wr_data,
        output stall_req, fifo_count,
        input  src1, src2,
        output hazard1, hazard2
    );

    modport master (
        output a_we, a_dest, a_data,
        output b_valid, b_dest, b_data,
        input  b_ready,
        input  wr_en, wr_dest, wr_data,
        input  stall_req, fifo_count,
        output src1, src2,
        input  hazard1, hazard2
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Arbitrates one register-file write port between the pipeline
//                writeback (port A, absolute priority) and a multi-cycle unit
//                (port B). B results wait in a small FIFO. A newer A write to
//                the same register kills a buffered B entry. A head entry that
//                waits too long raises stall_req so it can drain.
//                Optional feature macro: REGFILE_WB_ARB_HAZARD_EN enables the
//                src1/src2 hazard lookup against live buffered entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int         c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         c_AGE_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [3:0] c_DEPTH_CNT = 4'(DEPTH);
    localparam logic [c_AGE_W-1:0] c_AGE_LIMIT = c_AGE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_STARVED = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [3:0]          r_dest [DEPTH];
    logic [31:0]         r_data [DEPTH];
    logic [DEPTH-1:0]    r_kill;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [3:0]          r_count;
    logic [c_AGE_W-1:0]  r_age;
    state_t              r_state;
    logic                r_stall;

    logic                w_b_ready;
    logic                w_push;
    logic                w_head_present;
    logic                w_head_killed;
    logic [3:0]          w_head_dest;
    logic [31:0]         w_head_data;
    logic                w_pop_live;
    logic                w_pop_kill;
    logic                w_pop;
    logic [3:0]          w_count_next;
    logic [c_AGE_W-1:0]  w_age_next;
    logic [DEPTH-1:0]    w_occ;
    logic [DEPTH-1:0]    w_live;

    // Head view: held stable while the head waits behind port A
    assign w_head_present = (r_count != 4'd0);
    assign w_head_killed  = r_kill[r_rd_ptr];
    assign w_head_dest    = r_dest[r_rd_ptr];
    assign w_head_data    = r_data[r_rd_ptr];

    // Acceptance depends only on the registered count, so a same-cycle pop
    // never opens a slot for B
    assign w_b_ready = !rst && (r_count < c_DEPTH_CNT);
    assign w_push    = bus.b_valid && w_b_ready;

    // A live head writes only when A is idle; a killed head is discarded
    // silently in any cycle
    assign w_pop_live = !rst && w_head_present && !w_head_killed && !bus.a_we;
    assign w_pop_kill = !rst && w_head_present && w_head_killed;
    assign w_pop      = w_pop_live || w_pop_kill;

    assign w_count_next = r_count + {3'b000, w_push} - {3'b000, w_pop};

    // Register-file write port: A passes straight through, otherwise the head
    assign bus.wr_en      = bus.a_we || w_pop_live;
    assign bus.wr_dest    = bus.a_we ? bus.a_dest : w_head_dest;
    assign bus.wr_data    = bus.a_we ? bus.a_data : w_head_data;
    assign bus.b_ready    = w_b_ready;
    assign bus.stall_req  = r_stall;
    assign bus.fifo_count = r_count;

    // Slot occupancy: a slot is held if its distance from the read pointer is
    // below the count. Live means held and not superseded by an A write.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
        logic [c_PTR_W-1:0] w_offset;
        assign w_offset    = c_PTR_W'(gi) - r_rd_ptr;
        assign w_occ[gi]   = (4'(w_offset) < r_count);
        assign w_live[gi]  = w_occ[gi] && !r_kill[gi];
    end

`ifdef REGFILE_WB_ARB_HAZARD_EN
    logic w_haz1;
    logic w_haz2;

    // Flag a source operand whose newest value is still waiting in the FIFO
    always_comb begin
        w_haz1 = 1'b0;
        w_haz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i] && (r_dest[i] == bus.src1)) w_haz1 = 1'b1;
            if (w_live[i] && (r_dest[i] == bus.src2)) w_haz2 = 1'b1;
        end
    end

    assign bus.hazard1 = w_haz1;
    assign bus.hazard2 = w_haz2;
`else
    logic w_unused_hazard;
    assign w_unused_hazard = ^{bus.src1, bus.src2, w_live};
    assign bus.hazard1     = 1'b0;
    assign bus.hazard2     = 1'b0;
`endif

    // Head age: counts cycles a live head is left waiting, saturating
    always_comb begin
        w_age_next = r_age;
        if (!w_head_present || w_pop) begin
            w_age_next = '0;
        end else if (r_age < c_AGE_LIMIT) begin
            w_age_next = r_age + c_AGE_W'(1);
        end
    end

    // Entry storage and kill marking; a newer A write supersedes older B data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kill <= '0;
        end else begin
            if (bus.a_we) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_dest[i] == bus.a_dest) r_kill[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_dest[r_wr_ptr] <= bus.b_dest;
                r_data[r_wr_ptr] <= bus.b_data;
                r_kill[r_wr_ptr] <= 1'b0;
            end
        end
    end

    // Pointers, occupancy count and head age
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 4'd0;
            r_age    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= w_count_next;
            r_age   <= w_age_next;
        end
    end

    // Drain state machine; stall_req is a registered decode of STARVED
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_count_next != 4'd0) r_state <= S_DRAIN;
                    r_stall <= 1'b0;
                end
                S_DRAIN: begin
                    if (w_count_next == 4'd0) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end else if (w_age_next == c_AGE_LIMIT) begin
                        r_state <= S_STARVED;
                        r_stall <= 1'b1;
                    end else begin
                        r_stall <= 1'b0;
                    end
                end
                S_STARVED: begin
                    if (w_pop) begin
                        r_state <= (w_count_next == 4'd0) ? S_IDLE : S_DRAIN;
                        r_stall <= 1'b0;
                    end else begin
                        r_stall <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter. Directed
//                scenarios followed by randomized traffic compared against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef REGFILE_WB_ARB_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: queue of buffered results, oldest first
    typedef struct {
        logic [3:0]  dest;
        logic [31:0] data;
        bit          killed;
    } ent_t;

    ent_t        q[$];
    int          m_age;
    bit          m_stall;

    bit          e_b_ready;
    bit          e_wr_en;
    logic [3:0]  e_wr_dest;
    logic [31:0] e_wr_data;
    bit          e_h1;
    bit          e_h2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic set_in(input logic r, input logic we, input logic [3:0] ad,
                          input logic [31:0] adat, input logic bv,
                          input logic [3:0] bd, input logic [31:0] bdat);
        rst         = r;
        bus.a_we    = we;
        bus.a_dest  = ad;
        bus.a_data  = adat;
        bus.b_valid = bv;
        bus.b_dest  = bd;
        bus.b_data  = bdat;
    endtask

    // Wait to mid-cycle and derive expected combinational outputs
    task automatic settle();
        @(negedge clk);
        e_b_ready = !rst && (q.size() < DEPTH);
        e_wr_dest = 4'hx;
        e_wr_data = 32'hx;
        if (bus.a_we) begin
            e_wr_en = 1'b1; e_wr_dest = bus.a_dest; e_wr_data = bus.a_data;
        end else if (!rst && q.size() > 0 && !q[0].killed) begin
            e_wr_en = 1'b1; e_wr_dest = q[0].dest; e_wr_data = q[0].data;
        end else begin
            e_wr_en = 1'b0;
        end
        e_h1 = 1'b0;
        e_h2 = 1'b0;
        if (HAZ) begin
            foreach (q[i]) begin
                if (!q[i].killed && q[i].dest == bus.src1) e_h1 = 1'b1;
                if (!q[i].killed && q[i].dest == bus.src2) e_h2 = 1'b1;
            end
        end
    endtask

    // Clock edge: apply the arbitration rules to the model
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_age   = 0;
            m_stall = 1'b0;
        end else begin
            int   n0;
            bit   popped;
            bit   push;
            ent_t e;
            n0     = q.size();
            popped = 1'b0;
            push   = bus.b_valid && (n0 < DEPTH);
            if (n0 > 0 && (q[0].killed || !bus.a_we)) begin
                void'(q.pop_front());
                popped = 1'b1;
            end
            if (bus.a_we) begin
                foreach (q[i]) if (q[i].dest == bus.a_dest) q[i].killed = 1'b1;
            end
            if (push) begin
                e.dest = bus.b_dest; e.data = bus.b_data; e.killed = 1'b0;
                q.push_back(e);
            end
            if (n0 == 0 || popped) m_age = 0;
            else if (m_age < LIMIT) m_age++;
            m_stall = (q.size() > 0) && (m_age == LIMIT);
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 1, 4'd2, 32'h1234, 1, 4'd6, 32'h55);
        settle();
        n_checks++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL rst_a_pass wr_en: got %0b expected 1", bus.wr_en); end
        n_checks++; if (bus.wr_data !== 32'h1234) begin n_fail++; $display("FAIL rst_a_pass wr_data: got %0h expected 1234", bus.wr_data); end
        n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %0b expected 0", bus.b_ready); end
        advance();
        set_in(1, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %0b expected 0", bus.wr_en); end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if (bus.fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
        n_checks++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", bus.stall_req); end
        n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready: got %0b expected 1", bus.b_ready); end
        advance();
    endtask

    task automatic test_single_push();
        set_in(0, 0, 0, 0, 1, 4'd5, 32'hAA);
        settle();
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %0b expected 0", bus.wr_en); end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if (bus.fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", bus.fifo_count); end
        n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_dest !== 4'd5 || bus.wr_data !== 32'hAA) begin
            n_fail++; $display("FAIL single_write: got en=%0b dest=%0d data=%0h expected en=1 dest=5 data=aa", bus.wr_en, bus.wr_dest, bus.wr_data); end
        advance();
        settle();
        n_checks++; if (bus.fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", bus.fifo_count); end
        advance();
    endtask

    task automatic test_full();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, 4'd0, 32'(k), 1, 4'(10 + k), 32'hB0 + 32'(k));
            settle();
            n_checks++; if (bus.b_ready !== (k < 2)) begin n_fail++; $display("FAIL full_b_ready%0d: got %0b expected %0b", k, bus.b_ready, k < 2); end
            n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'(k)) begin n_fail++; $display("FAIL full_a_write%0d: got %0b/%0h expected 1/%0h", k, bus.wr_en, bus.wr_data, k); end
            if (k == 2) begin
                n_checks++; if (bus.fifo_count !== 4'd2) begin n_fail++; $display("FAIL full_count: got %0d expected 2", bus.fifo_count); end
            end
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0);
            settle();
            n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_dest !== 4'(10 + k) || bus.wr_data !== 32'hB0 + 32'(k)) begin
                n_fail++; $display("FAIL full_drain%0d: got %0b/%0d/%0h expected 1/%0d/%0h", k, bus.wr_en, bus.wr_dest, bus.wr_data, 10 + k, 32'hB0 + k); end
            advance();
        end
        settle();
        n_checks++; if (bus.wr_en !== 1'b0 || bus.fifo_count !== 4'd0) begin n_fail++; $display("FAIL full_empty: got en=%0b cnt=%0d expected en=0 cnt=0", bus.wr_en, bus.fifo_count); end
        advance();
    endtask

    task automatic test_kill();
        set_in(0, 0, 0, 0, 1, 4'd3, 32'h33);
        settle();
        advance();
        set_in(0, 1, 4'd3, 32'h11, 0, 0, 0);
        settle();
        n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_dest !== 4'd3 || bus.wr_data !== 32'h11) begin
            n_fail++; $display("FAIL kill_a_write: got %0b/%0d/%0h expected 1/3/11", bus.wr_en, bus.wr_dest, bus.wr_data); end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL kill_no_write: got %0b expected 0", bus.wr_en); end
        n_checks++; if (bus.fifo_count !== 4'd1) begin n_fail++; $display("FAIL kill_count1: got %0d expected 1", bus.fifo_count); end
        advance();
        settle();
        n_checks++; if (bus.fifo_count !== 4'd0 || bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL kill_popped: got cnt=%0d en=%0b expected 0/0", bus.fifo_count, bus.wr_en); end
        advance();
    endtask

    task automatic test_starve();
        for (int k = 0; k < 5; k++) begin
            set_in(0, 1, 4'd1, 32'h100 + 32'(k), (k == 0), 4'd9, 32'h99);
            settle();
            n_checks++; if (bus.stall_req !== 1'b0 || bus.wr_dest !== 4'd1) begin
                n_fail++; $display("FAIL starve_wait%0d: got stall=%0b dest=%0d expected 0/1", k, bus.stall_req, bus.wr_dest); end
            advance();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %0b expected 1", bus.stall_req); end
        n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_dest !== 4'd9 || bus.wr_data !== 32'h99) begin
            n_fail++; $display("FAIL starve_drain: got %0b/%0d/%0h expected 1/9/99", bus.wr_en, bus.wr_dest, bus.wr_data); end
        advance();
        settle();
        n_checks++; if (bus.stall_req !== 1'b0 || bus.fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL starve_release: got stall=%0b cnt=%0d expected 0/0", bus.stall_req, bus.fifo_count); end
        advance();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 1, 4'd0, 32'h0, 1, 4'(12 + k), 32'hC0 + 32'(k));
            settle();
            advance();
        end
        set_in(1, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if (bus.wr_en !== 1'b0 || bus.b_ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_in_reset: got en=%0b rdy=%0b expected 0/0", bus.wr_en, bus.b_ready); end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            settle();
            n_checks++; if (bus.fifo_count !== 4'd0 || bus.wr_en !== 1'b0 || bus.stall_req !== 1'b0) begin
                n_fail++; $display("FAIL rmid_after%0d: got cnt=%0d en=%0b stall=%0b expected 0/0/0", k, bus.fifo_count, bus.wr_en, bus.stall_req); end
            advance();
        end
    endtask

    task automatic test_hazard();
        set_in(0, 1, 4'd0, 32'h0, 1, 4'd7, 32'h77);
        settle();
        advance();
        bus.src1 = 4'd7;
        bus.src2 = 4'd2;
        set_in(0, 1, 4'd0, 32'h0, 0, 0, 0);
        settle();
        n_checks++; if (bus.hazard1 !== HAZ) begin n_fail++; $display("FAIL hazard1_set: got %0b expected %0b", bus.hazard1, HAZ); end
        n_checks++; if (bus.hazard2 !== 1'b0) begin n_fail++; $display("FAIL hazard2_clear: got %0b expected 0", bus.hazard2); end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        settle();
        advance();
        settle();
        n_checks++; if (bus.hazard1 !== 1'b0) begin n_fail++; $display("FAIL hazard1_after_pop: got %0b expected 0", bus.hazard1); end
        advance();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int pct;
            pct = ((cyc / 40) % 3 == 0) ? 30 : (((cyc / 40) % 3 == 1) ? 70 : 95);
            set_in(($urandom_range(0, 59) == 0),
                   ($urandom_range(0, 99) < pct), 4'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 3)), $urandom);
            bus.src1 = 4'($urandom_range(0, 3));
            bus.src2 = 4'($urandom_range(0, 3));
            settle();
            n_checks++; if (bus.b_ready !== e_b_ready) begin n_fail++; $display("FAIL rnd_b_ready@%0d: got %0b expected %0b", cyc, bus.b_ready, e_b_ready); end
            n_checks++; if (bus.wr_en !== e_wr_en) begin n_fail++; $display("FAIL rnd_wr_en@%0d: got %0b expected %0b", cyc, bus.wr_en, e_wr_en); end
            if (e_wr_en) begin
                n_checks++; if (bus.wr_dest !== e_wr_dest || bus.wr_data !== e_wr_data) begin
                    n_fail++; $display("FAIL rnd_wr@%0d: got %0d/%0h expected %0d/%0h", cyc, bus.wr_dest, bus.wr_data, e_wr_dest, e_wr_data); end
            end
            n_checks++; if (bus.fifo_count !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, bus.fifo_count, q.size()); end
            n_checks++; if (bus.stall_req !== m_stall) begin n_fail++; $display("FAIL rnd_stall@%0d: got %0b expected %0b", cyc, bus.stall_req, m_stall); end
            n_checks++; if (bus.hazard1 !== e_h1 || bus.hazard2 !== e_h2) begin
                n_fail++; $display("FAIL rnd_hazard@%0d: got %0b%0b expected %0b%0b", cyc, bus.hazard1, bus.hazard2, e_h1, e_h2); end
            advance();
        end
    endtask

    initial begin
        bus.src1 = 4'd0;
        bus.src2 = 4'd0;
        q.delete();
        m_age   = 0;
        m_stall = 1'b0;
        test_reset();
        test_single_push();
        test_full();
        test_kill();
        test_starve();
        test_reset_mid();
        test_hazard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning deferred-write FIFO entries (power of two, 2..8).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning head-entry wait cycles before a stall request.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports a_we/a_dest/a_data  in  1/4/32  pipeline writeback (port A); no backpressure.
REQ-006 SHALL have ports b_valid/b_dest/b_data  in  1/4/32  multi-cycle unit result (port B).
REQ-007 SHALL have port b_ready  out  1  port B accept.
REQ-008 SHALL have ports wr_en/wr_dest/wr_data  out  1/4/32  register-file write port (Dest_wb/Result_WB/writeBackEn).
REQ-009 SHALL have port stall_req  out  1  request pipeline freeze so port B can drain.
REQ-010 SHALL have port fifo_count  out  4  live + killed entries held.
REQ-011 SHALL have ports src1/src2  in  4 each  and hazard1/hazard2  out  1 each  (see Configuration).

Function
REQ-012 SHALL set b_ready = (fifo_count < DEPTH), from registered count only; push occurs when b_valid && b_ready.
REQ-013 SHALL drive the write port combinationally: a_we=1 -> wr_en=1, wr_dest=a_dest, wr_data=a_data (zero latency); else if the head entry is live -> write head and pop; else wr_en=0.
REQ-014 SHALL never drop or delay a port A write; A has absolute priority, including while stall_req=1.
REQ-015 SHALL not bypass: a pushed entry is first eligible for writing the cycle after the push.
REQ-016 SHALL, when a_we=1, mark every buffered entry with dest==a_dest as killed (write-after-write ordering: newer A value wins).
REQ-017 SHALL pop a killed head in any cycle (regardless of a_we) without asserting wr_en for it.
REQ-018 SHALL allow push and pop in the same cycle; count unchanged; wrap-around of read/write pointers modulo DEPTH.
REQ-019 SHALL keep an age counter: increments each cycle a live head is present and not popped, saturates at STARVE_LIMIT, clears on pop or when FIFO empty.
REQ-020 SHALL implement FSM IDLE (count==0), DRAIN (count>0, age<STARVE_LIMIT), STARVED (age==STARVE_LIMIT); STARVED -> DRAIN/IDLE the cycle after the head pops.
REQ-021 SHALL register stall_req = 1 exactly while in STARVED.
REQ-022 SHALL keep data_out and dest_out stable and equal to head contents while the head waits.

Reset
REQ-023 SHALL, on rst=1 at posedge, clear pointers, count, kill bits, age; state=IDLE; stall_req=0.
REQ-024 SHALL, during rst, force b_ready=0 and wr_en=0 for head entries; a_we pass-through still drives wr_en (register file reset has priority).
REQ-025 SHALL discard buffered entries on reset mid-operation; no write of them after reset.

Configuration
REQ-026 SHALL, with REGFILE_WB_ARB_HAZARD_EN defined, set hazardN=1 when srcN equals the dest of any live buffered entry.
REQ-027 SHALL, without REGFILE_WB_ARB_HAZARD_EN, tie hazard1/hazard2 to 0; port list unchanged.

Verification
REQ-028 SHALL test: b push dest=5 data=0xAA, a_we=0 -> next cycle wr_en=1, wr_dest=5, wr_data=0xAA, fifo_count 1->0.
REQ-029 SHALL test: DEPTH=2, three b_valid cycles with a_we=1 -> b_ready=0 on third, count=2, no entry lost.
REQ-030 SHALL test: buffered dest=3, then a_we dest=3 data=0x11 -> reg3 write 0x11 only; killed entry popped with wr_en=0.
REQ-031 SHALL test: one entry buffered, a_we=1 continuously -> stall_req=1 after 4 cycles; a_we dropped -> entry written, stall_req=0 next cycle.
REQ-032 SHALL test: rst asserted with count=2 -> next cycle count=0, IDLE, no buffered write ever appears.
REQ-033 SHALL test (HAZARD_EN): buffered dest=7, src1=7, src2=2 -> hazard1=1, hazard2=0; after pop hazard1=0.
